// File: rtl/overcooked_pkg.sv
// Shared keycodes, facing and controller-state encodings for the penguin sprite path.
package overcooked_pkg;

  localparam logic [7:0] KEY_W = 8'h1A;
  localparam logic [7:0] KEY_A = 8'h04;
  localparam logic [7:0] KEY_S = 8'h16;
  localparam logic [7:0] KEY_D = 8'h07;
  localparam logic [7:0] KEY_E = 8'h08;

  typedef enum logic [1:0] {UP = 2'd0, DOWN = 2'd1, LEFT = 2'd2, RIGHT = 2'd3} facing_t;

  typedef enum logic [1:0] {IDLE = 2'd0, WAIT = 2'd1, COOLDOWN = 2'd2} ctrl_state_t;

endpackage

// File: rtl/penguin_key_decode.sv
// Combinational HID keycode decode: direction keys to facing, E to interact.
module penguin_key_decode
  import overcooked_pkg::*;
(
  input  logic [7:0] keycode,
  output logic       dir_valid,
  output facing_t    dir,
  output logic       interact
);

  always_comb begin
    dir_valid = 1'b1;
    dir       = UP;
    interact  = (keycode == KEY_E);
    case (keycode)
      KEY_W:   dir = UP;
      KEY_S:   dir = DOWN;
      KEY_A:   dir = LEFT;
      KEY_D:   dir = RIGHT;
      default: dir_valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/penguin_motion_ctrl.sv
// Per-frame penguin movement with wall blocking, plus an interact req/ack handshake
// (IDLE/WAIT/COOLDOWN). All outputs registered; position/facing update one Clk after frame_pulse.
module penguin_motion_ctrl
  import overcooked_pkg::*;
#(
  parameter int STEP            = 1,
  parameter int X_START         = 100,
  parameter int Y_START         = 100,
  parameter int X_MAX           = 600,
  parameter int Y_MAX           = 440,
  parameter int COOLDOWN_FRAMES = 8,
  parameter int TIMEOUT_FRAMES  = 30
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_pulse,
  input  logic [7:0] keycode,
  input  logic       touchUp,
  input  logic       touchDown,
  input  logic       touchLeft,
  input  logic       touchRight,
  input  logic [9:0] nearUpX,
  input  logic [9:0] nearUpY,
  input  logic [9:0] nearDownX,
  input  logic [9:0] nearDownY,
  input  logic [9:0] nearLeftX,
  input  logic [9:0] nearLeftY,
  input  logic [9:0] nearRightX,
  input  logic [9:0] nearRightY,
  input  logic       interact_ack,
  output logic [9:0] penguinX,
  output logic [9:0] penguinY,
  output logic [1:0] facing,
  output logic       interact_req,
  output logic [9:0] interact_x,
  output logic [9:0] interact_y,
  output logic       busy
);

  ctrl_state_t state_q, state_d;
  facing_t     facing_q, facing_d;
  logic [9:0]  x_q, x_d, y_q, y_d, ix_q, ix_d, iy_q, iy_d;
  logic        req_q, req_d, busy_q, busy_d, prev_e_q, prev_e_d;
  logic [3:0]  cool_q, cool_d;
  logic [4:0]  tmo_q, tmo_d;

  logic        dir_valid, key_interact;
  facing_t     dir;
  logic [3:0]  touch_vec;
  logic [10:0] x_inc, y_inc;
  logic [9:0]  near_x, near_y;

  penguin_key_decode u_decode (
    .keycode  (keycode),
    .dir_valid(dir_valid),
    .dir      (dir),
    .interact (key_interact)
  );

  assign touch_vec = {touchRight, touchLeft, touchDown, touchUp};
  assign x_inc     = {1'b0, x_q} + 11'(STEP);
  assign y_inc     = {1'b0, y_q} + 11'(STEP);

  always_comb begin
    state_d  = state_q;
    facing_d = facing_q;
    x_d      = x_q;
    y_d      = y_q;
    ix_d     = ix_q;
    iy_d     = iy_q;
    req_d    = req_q;
    prev_e_d = prev_e_q;
    cool_d   = cool_q;
    tmo_d    = tmo_q;
    near_x   = nearUpX;
    near_y   = nearUpY;

    case (facing_q)
      DOWN:    begin near_x = nearDownX;  near_y = nearDownY;  end
      LEFT:    begin near_x = nearLeftX;  near_y = nearLeftY;  end
      RIGHT:   begin near_x = nearRightX; near_y = nearRightY; end
      default: begin near_x = nearUpX;    near_y = nearUpY;    end
    endcase

    if (frame_pulse) prev_e_d = key_interact;

    case (state_q)
      IDLE: begin
        if (frame_pulse && key_interact && !prev_e_q && touch_vec[facing_q]) begin
          ix_d    = near_x;
          iy_d    = near_y;
          req_d   = 1'b1;
          tmo_d   = '0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        // Ack takes priority over a timeout landing in the same cycle.
        if (interact_ack) begin
          req_d   = 1'b0;
          cool_d  = 4'(COOLDOWN_FRAMES);
          state_d = COOLDOWN;
        end else if (frame_pulse) begin
          tmo_d = tmo_q + 5'd1;
          if (tmo_d == 5'(TIMEOUT_FRAMES)) begin
            req_d   = 1'b0;
            state_d = IDLE;
          end
        end
      end
      COOLDOWN: begin
        if (frame_pulse) begin
          cool_d = cool_q - 4'd1;
          if (cool_d == '0) state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Touch flags describe the pre-move position, so blocking uses the current position.
    if (frame_pulse && dir_valid && state_q != WAIT) begin
      facing_d = dir;
      if (!touch_vec[dir]) begin
        case (dir)
          UP:      y_d = (y_q >= 10'(STEP)) ? y_q - 10'(STEP) : '0;
          DOWN:    y_d = (y_inc > 11'(Y_MAX)) ? 10'(Y_MAX) : y_inc[9:0];
          LEFT:    x_d = (x_q >= 10'(STEP)) ? x_q - 10'(STEP) : '0;
          default: x_d = (x_inc > 11'(X_MAX)) ? 10'(X_MAX) : x_inc[9:0];
        endcase
      end
    end

    busy_d = (state_d == WAIT);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q  <= IDLE;
      facing_q <= DOWN;
      x_q      <= 10'(X_START);
      y_q      <= 10'(Y_START);
      ix_q     <= '0;
      iy_q     <= '0;
      req_q    <= 1'b0;
      busy_q   <= 1'b0;
      prev_e_q <= 1'b0;
      cool_q   <= '0;
      tmo_q    <= '0;
    end else begin
      state_q  <= state_d;
      facing_q <= facing_d;
      x_q      <= x_d;
      y_q      <= y_d;
      ix_q     <= ix_d;
      iy_q     <= iy_d;
      req_q    <= req_d;
      busy_q   <= busy_d;
      prev_e_q <= prev_e_d;
      cool_q   <= cool_d;
      tmo_q    <= tmo_d;
    end
  end

  assign penguinX     = x_q;
  assign penguinY     = y_q;
  assign facing       = facing_q;
  assign interact_req = req_q;
  assign interact_x   = ix_q;
  assign interact_y   = iy_q;
  assign busy         = busy_q;

endmodule

// File: tb/tb_penguin_motion_ctrl.sv
// Scoreboard bench for penguin_motion_ctrl: a behavioural model pushes expected outputs per cycle.
module tb_penguin_motion_ctrl;

  logic       Clk = 1'b0;
  logic       Reset = 1'b1;
  logic       frame_pulse = 1'b0;
  logic [7:0] keycode = 8'h00;
  logic       touchUp = 1'b0, touchDown = 1'b0, touchLeft = 1'b0, touchRight = 1'b0;
  logic [9:0] near_x [4];
  logic [9:0] near_y [4];
  logic       interact_ack = 1'b0;
  logic [9:0] penguinX, penguinY, interact_x, interact_y;
  logic [1:0] facing;
  logic       interact_req, busy;

  penguin_motion_ctrl dut (
    .Clk(Clk), .Reset(Reset), .frame_pulse(frame_pulse), .keycode(keycode),
    .touchUp(touchUp), .touchDown(touchDown), .touchLeft(touchLeft), .touchRight(touchRight),
    .nearUpX(near_x[0]), .nearUpY(near_y[0]), .nearDownX(near_x[1]), .nearDownY(near_y[1]),
    .nearLeftX(near_x[2]), .nearLeftY(near_y[2]), .nearRightX(near_x[3]), .nearRightY(near_y[3]),
    .interact_ack(interact_ack),
    .penguinX(penguinX), .penguinY(penguinY), .facing(facing), .interact_req(interact_req),
    .interact_x(interact_x), .interact_y(interact_y), .busy(busy)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    int x; int y; int f; int req; int ix; int iy; int busy;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   req_rises = 0;
  logic req_prev = 1'b0;

  // Reference model state: m_state 0=IDLE 1=WAIT 2=COOLDOWN
  int m_state, mx, my, mf, mreq, mix, miy, mcool, mtmo;
  bit mprev;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_state = 0; mx = 100; my = 100; mf = 1; mreq = 0; mix = 0; miy = 0;
    mcool = 0; mtmo = 0; mprev = 0;
  endtask

  task automatic model_step();
    int dir, ns;
    logic [3:0] t;
    bit is_e;
    t    = {touchRight, touchLeft, touchDown, touchUp};
    is_e = (keycode == 8'h08);
    dir  = (keycode == 8'h1A) ? 0 : (keycode == 8'h16) ? 1 :
           (keycode == 8'h04) ? 2 : (keycode == 8'h07) ? 3 : -1;
    ns = m_state;
    if (m_state == 1) begin
      if (interact_ack) begin
        mreq = 0; mcool = 8; ns = 2;
      end else if (frame_pulse) begin
        mtmo++;
        if (mtmo == 30) begin mreq = 0; ns = 0; end
      end
    end else if (frame_pulse) begin
      if (m_state == 0 && is_e && !mprev && t[mf]) begin
        mix = near_x[mf]; miy = near_y[mf]; mreq = 1; mtmo = 0; ns = 1;
      end
      if (m_state == 2) begin
        mcool--;
        if (mcool == 0) ns = 0;
      end
      if (dir >= 0) begin
        mf = dir;
        if (!t[dir]) begin
          case (dir)
            0: my = (my > 0) ? my - 1 : 0;
            1: my = (my < 440) ? my + 1 : 440;
            2: mx = (mx > 0) ? mx - 1 : 0;
            default: mx = (mx < 600) ? mx + 1 : 600;
          endcase
        end
      end
    end
    if (frame_pulse) mprev = is_e;
    m_state = ns;
  endtask

  // One clock: model predicts, scoreboard holds the prediction until the DUT output settles.
  task automatic cycle();
    exp_t e;
    model_step();
    e = '{mx, my, mf, mreq, mix, miy, (m_state == 1) ? 1 : 0};
    sb.push_back(e);
    @(negedge Clk);
    e = sb.pop_front();
    check("penguinX", 32'(penguinX), 32'(e.x));
    check("penguinY", 32'(penguinY), 32'(e.y));
    check("facing", 32'(facing), 32'(e.f));
    check("interact_req", 32'(interact_req), 32'(e.req));
    check("interact_x", 32'(interact_x), 32'(e.ix));
    check("interact_y", 32'(interact_y), 32'(e.iy));
    check("busy", 32'(busy), 32'(e.busy));
    if (interact_req && !req_prev) req_rises++;
    req_prev = interact_req;
  endtask

  task automatic frame(input logic [7:0] k, input logic ack_with = 1'b0,
                       input logic ack_after = 1'b0);
    keycode = k;
    frame_pulse = 1'b1;
    interact_ack = ack_with;
    cycle();
    frame_pulse = 1'b0;
    interact_ack = ack_after;
    cycle();
    interact_ack = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0;
    near_x[0] = 10'd5;  near_y[0] = 10'd6;
    near_x[1] = 10'd60; near_y[1] = 10'd380;
    near_x[2] = 10'd7;  near_y[2] = 10'd8;
    near_x[3] = 10'd9;  near_y[3] = 10'd11;
    model_reset();
    repeat (3) @(negedge Clk);
    check("rst_x", 32'(penguinX), 32'd100);
    check("rst_y", 32'(penguinY), 32'd100);
    check("rst_facing", 32'(facing), 32'd1);
    check("rst_req", 32'(interact_req), 32'd0);
    check("rst_ix", 32'(interact_x), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    Reset = 1'b0;
    cycle();

    // D held five frames, no wall
    repeat (5) frame(8'h07);
    check("d5_x", 32'(penguinX), 32'd105);
    check("d5_facing", 32'(facing), 32'd3);

    // S against a wall below
    touchDown = 1'b1;
    repeat (2) frame(8'h16);
    check("s_blocked_y", 32'(penguinY), 32'd100);
    check("s_facing", 32'(facing), 32'd1);

    // Interact facing down, ack three cycles after req rises
    keycode = 8'h08; frame_pulse = 1'b1; cycle(); frame_pulse = 1'b0;
    check("req_rise", 32'(interact_req), 32'd1);
    check("ix_latch", 32'(interact_x), 32'd60);
    check("iy_latch", 32'(interact_y), 32'd380);
    check("busy_wait", 32'(busy), 32'd1);
    repeat (2) cycle();
    interact_ack = 1'b1; cycle(); interact_ack = 1'b0;
    check("req_fall", 32'(interact_req), 32'd0);
    check("busy_cool", 32'(busy), 32'd0);

    // Cooldown: an E press inside it is ignored
    r0 = req_rises;
    frame(8'h00); frame(8'h00); frame(8'h08);
    repeat (5) frame(8'h00);
    check("cool_no_req", 32'(req_rises - r0), 32'd0);

    // E held four frames with immediate ack: one request only
    r0 = req_rises;
    frame(8'h08, 1'b0, 1'b1);
    repeat (3) frame(8'h08);
    check("held_e_one_req", 32'(req_rises - r0), 32'd1);
    r0 = req_rises;
    frame(8'h00); frame(8'h08);
    repeat (3) frame(8'h00);
    check("cool2_no_req", 32'(req_rises - r0), 32'd0);
    frame(8'h08, 1'b0, 1'b1);
    check("after_cool_req", 32'(req_rises - r0), 32'd1);
    repeat (8) frame(8'h00);

    // Timeout: 30 frames with W held, no ack, no movement
    frame(8'h08);
    repeat (29) frame(8'h1A);
    check("tmo29_req", 32'(interact_req), 32'd1);
    frame(8'h1A);
    check("tmo30_req", 32'(interact_req), 32'd0);
    check("tmo_busy", 32'(busy), 32'd0);
    check("tmo_y_frozen", 32'(penguinY), 32'd100);

    // Ack and the timeout pulse in the same cycle: ack wins, cooldown follows
    frame(8'h08);
    repeat (29) frame(8'h00);
    frame(8'h00, 1'b1);
    r0 = req_rises;
    frame(8'h08);
    check("ack_wins_no_req", 32'(req_rises - r0), 32'd0);
    repeat (8) frame(8'h00);

    // Saturation at Y=0
    repeat (102) frame(8'h1A);
    check("sat_y0", 32'(penguinY), 32'd0);
    check("sat_facing", 32'(facing), 32'd0);

    // Asynchronous reset in the middle of WAIT
    touchUp = 1'b1;
    frame(8'h00);
    frame(8'h08);
    check("pre_rst_req", 32'(interact_req), 32'd1);
    check("pre_rst_ix", 32'(interact_x), 32'd5);
    #2 Reset = 1'b1;
    #1;
    check("arst_req", 32'(interact_req), 32'd0);
    check("arst_x", 32'(penguinX), 32'd100);
    check("arst_y", 32'(penguinY), 32'd100);
    check("arst_busy", 32'(busy), 32'd0);
    model_reset();
    req_prev = 1'b0;
    @(negedge Clk);
    Reset = 1'b0;
    touchUp = 1'b0;
    frame(8'h04);
    check("post_rst_x", 32'(penguinX), 32'd99);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/penguin_motion_ctrl.md
# penguin_motion_ctrl

Sequencing controller for the penguin sprite. Once per frame it samples the keyboard and the four wall-contact detectors (up/down/left/right), then either advances the penguin position or blocks the move. On an interact key press it latches the nearest-counter coordinates from the detector the penguin is facing and runs a req/ack handshake with the counter item store. It sits between the USB keycode path and the sprite/color mapper.

## Interface
- STEP, 1: pixels moved per frame.
- X_START, 100 / Y_START, 100: reset position.
- X_MAX, 600 / Y_MAX, 440: position clamp, inclusive.
- COOLDOWN_FRAMES, 8: frames after an interaction during which interact is ignored.
- TIMEOUT_FRAMES, 30: frames to wait for ack before aborting.
- Clk  in  1  system clock.
- Reset  in  1  asynchronous, active-high.
- frame_pulse  in  1  one-Clk pulse per vsync.
- keycode  in  8  HID keycode: W=0x1A, A=0x04, S=0x16, D=0x07, interact E=0x08, 0x00=none.
- touchUp, touchDown, touchLeft, touchRight  in  1 each  detector flags, combinational from current position.
- nearUpX/Y, nearDownX/Y, nearLeftX/Y, nearRightX/Y  in  10 each  detector nearest-counter coordinates; valid only while the matching flag is 1.
- interact_ack  in  1  item store accepts the request.
- penguinX, penguinY  out  10  registered position; reset X_START/Y_START.
- facing  out  2  0=up, 1=down, 2=left, 3=right; reset 1 (down).
- interact_req  out  1  reset 0.
- interact_x, interact_y  out  10  latched counter coordinates; reset 0.
- busy  out  1  high in WAIT; reset 0.

## Operation
- States: IDLE, WAIT, COOLDOWN. Reset enters IDLE and clears cooldown/timeout counters and the prev-interact flag.
- Movement (IDLE and COOLDOWN, on frame_pulse only):
  - A direction key sets facing.
  - If that direction's touch flag is 0, move STEP in that direction, saturating at 0 and X_MAX/Y_MAX (unsigned 10-bit, no wrap).
  - If the flag is 1, position is unchanged and facing still updates.
  - Any other keycode produces no movement.
- Interact (IDLE only, on frame_pulse):
  - Triggers when keycode==0x08 and the keycode on the previous frame_pulse was not 0x08 (rising edge). A held key does not retrigger.
  - If the touch flag for facing is 1: latch that detector's near X/Y into interact_x/y, assert interact_req, clear the timeout counter, go to WAIT.
  - Otherwise stay in IDLE; no request.
- WAIT:
  - Position is frozen and direction keys are ignored.
  - interact_req and interact_x/y stay stable until ack.
  - interact_ack=1 on any cycle: deassert req on the next edge, load cooldown=COOLDOWN_FRAMES, go to COOLDOWN.
  - Each frame_pulse increments the timeout counter. On reaching TIMEOUT_FRAMES with no ack: drop req and go to IDLE without cooldown.
  - If ack and the timeout frame_pulse arrive in the same cycle, ack wins.
- COOLDOWN:
  - Movement is allowed; interact presses are ignored, but the prev-interact flag still updates.
  - Each frame_pulse decrements the counter. At 0, go to IDLE; the same pulse's movement still applies.
- interact_ack outside WAIT is ignored.

## Timing
- All outputs are registered.
- Position and facing change on the Clk edge after the cycle in which frame_pulse=1 (latency 1).
- interact_req rises 1 cycle after the triggering frame_pulse.
- interact_req falls 1 cycle after the ack cycle. A single-cycle ack is sufficient. Minimum req width is 1 cycle (ack in the first req cycle).
- Touch flags and near coordinates are sampled only in frame_pulse cycles. They reflect the pre-move position, so a block always uses the position before the update.
- Reset mid-WAIT drops interact_req asynchronously and returns the penguin to X_START/Y_START.

## Structure
- overcooked_pkg holds:
  - keycode constants KEY_W/A/S/D/E.
  - facing_t enum (UP, DOWN, LEFT, RIGHT).
  - ctrl_state_t enum (IDLE, WAIT, COOLDOWN).
- Sub-module penguin_key_decode (combinational): maps keycode to {dir_valid, dir facing_t, interact}.
- Wall detectors stay external; this block only consumes their outputs.

## Test plan
- Reset, then D held for 5 frames with touchRight=0 -> penguinX=105, penguinY=100, facing=3.
- S held with touchDown=1 -> penguinY unchanged at 100, facing=1.
- Facing down, touchDown=1, nearDown=(60,380), E pressed -> interact_req=1 one cycle after the pulse, interact_x=60, interact_y=380, busy=1. Ack 3 cycles later -> req=0 on the next edge, state COOLDOWN.
- E held across 4 frames, ack immediate -> exactly one request. Second press during the 8 cooldown frames is ignored. Press after cooldown ends -> new request.
- No ack for 30 frame pulses -> req drops and state is IDLE. W during WAIT -> no movement.
- Y=0 with W held and touchUp=0 -> penguinY stays 0 (saturation). Reset asserted mid-WAIT -> req=0 and position=(100,100) immediately.
